// File: rtl/smax_reduce.sv
// Streaming signed-maximum reducer: collects up to FRAME elements, then presents
// the frame maximum, its first index and the element count until consumed.
//
// state | meaning
// ACCUM | collecting input beats, in_ready high
// HOLD  | result presented on out_*, waiting for out_ready
module smax_reduce #(
    parameter  int WIDTH = 16,
    parameter  int FRAME = 8,
    localparam int IDX_W = $clog2(FRAME),
    localparam int CNT_W = $clog2(FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic take;
    logic last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        idx_d     = idx_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        // Strict greater-than keeps the earliest index on ties.
        take      = (cnt_q == '0) || ($signed(in_data) > $signed(max_q));
        last_beat = in_last || (cnt_q == CNT_W'(FRAME - 1));

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (take) begin
                        max_d = in_data;
                        idx_d = cnt_q[IDX_W-1:0];
                    end
                    if (last_beat) begin
                        count_d = cnt_q + CNT_W'(1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_smax_reduce.sv
// Self-checking bench for smax_reduce: directed vector table, backpressure and
// reset sequences, then random gapped frames against a behavioural model.
module tb_smax_reduce;

    localparam int WIDTH = 16;
    localparam int FRAME = 8;
    localparam int IDX_W = $clog2(FRAME);
    localparam int CNT_W = $clog2(FRAME + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_idx;
    logic [CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    smax_reduce #(.WIDTH(WIDTH), .FRAME(FRAME)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:FRAME-1][WIDTH-1:0] d;
        int                          n;
        logic                        use_last;
        logic [WIDTH-1:0]            emax;
        int                          eidx;
        int                          ecnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, waiting out any HOLD phase; gap = idle cycles before it.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input int gap);
        bit accepted;
        int tries;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        accepted = 1'b0;
        tries    = 0;
        while (!accepted && tries < 30) begin
            accepted = in_ready;
            tick();
            tries++;
        end
        if (!accepted) chk("beat_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    // Called right after the final beat's edge: result must already be valid.
    task automatic check_result(input string tag, input logic [WIDTH-1:0] emax,
                                input int eidx, input int ecnt, input int hold,
                                input bit push_during_hold);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ready_low"}, in_ready, 0);
        chk({tag, "_max"}, out_max, emax);
        chk({tag, "_idx"}, out_idx, eidx);
        chk({tag, "_count"}, out_count, ecnt);
        for (int k = 0; k < hold; k++) begin
            if (push_during_hold) begin
                in_valid = 1'b1;
                in_data  = WIDTH'($urandom);
                in_last  = 1'b1;
            end
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_max"}, out_max, emax);
            chk({tag, "_hold_idx"}, out_idx, eidx);
            chk({tag, "_hold_count"}, out_count, ecnt);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_ready"}, in_ready, 1);
    endtask

    task automatic run_frame(input string tag, input logic [0:FRAME-1][WIDTH-1:0] d,
                             input int n, input logic use_last, input int max_gap,
                             input logic [WIDTH-1:0] emax, input int eidx, input int ecnt,
                             input int hold, input bit push_during_hold);
        for (int i = 0; i < n; i++)
            send_beat(d[i], use_last && (i == n - 1), (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
        check_result(tag, emax, eidx, ecnt, hold, push_during_hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_max"}, out_max, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_count"}, out_count, 0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [0:FRAME-1][WIDTH-1:0] fr;
        logic [WIDTH-1:0] m;
        int n, mi;
        logic ul;

        vecs[0] = '{d: {16'd3, 16'hFFFB, 16'd7, 16'd7, 16'hFFFF, 16'd2, 16'd0, 16'd6},
                    n: 8, use_last: 1'b0, emax: 16'd7, eidx: 2, ecnt: 8};
        vecs[1] = '{d: {16'h8000, 16'hFFFF, 16'h8001, 80'h0},
                    n: 3, use_last: 1'b1, emax: 16'hFFFF, eidx: 1, ecnt: 3};
        vecs[2] = '{d: {16'h1234, 112'h0},
                    n: 1, use_last: 1'b1, emax: 16'h1234, eidx: 0, ecnt: 1};
        vecs[3] = '{d: {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 48'h0},
                    n: 5, use_last: 1'b1, emax: 16'h8000, eidx: 0, ecnt: 5};
        vecs[4] = '{d: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
                    n: 8, use_last: 1'b1, emax: 16'd8, eidx: 7, ecnt: 8};
        vecs[5] = '{d: {16'h7FFF, 16'h8000, 16'h7FFF, 80'h0},
                    n: 3, use_last: 1'b1, emax: 16'h7FFF, eidx: 0, ecnt: 3};

        #2;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        foreach (vecs[v])
            run_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].n, vecs[v].use_last, 0,
                      vecs[v].emax, vecs[v].eidx, vecs[v].ecnt, 0, 1'b0);

        // Backpressure with in_valid pushing junk during HOLD; the next frame must be intact.
        fr = {16'd10, 16'd40, 16'd20, 80'h0};
        run_frame("bp", fr, 3, 1'b1, 0, 16'd40, 1, 3, 5, 1'b1);
        fr = {16'hFFF0, 16'hFFF8, 16'hFFF8, 16'hFFF1, 64'h0};
        run_frame("bp_next", fr, 4, 1'b1, 0, 16'hFFF8, 1, 4, 0, 1'b0);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++) send_beat(16'd100 + WIDTH'(i), 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("midrst_rel");
        fr = {16'd9, 16'd1, 96'h0};
        run_frame("midrst_new", fr, 2, 1'b1, 0, 16'd9, 0, 2, 0, 1'b0);

        // Reset while a result is held.
        fr = {16'd5, 16'd6, 96'h0};
        for (int i = 0; i < 2; i++) send_beat(fr[i], i == 1, 0);
        chk("holdrst_valid_before", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("holdrst");
        tick();
        rst_n = 1'b1;
        tick();
        fr = {16'hFFFE, 112'h0};
        run_frame("holdrst_new", fr, 1, 1'b1, 0, 16'hFFFE, 0, 1, 0, 1'b0);

        // Random gapped frames against a plain first-maximum model.
        for (int f = 0; f < 40; f++) begin
            n  = $urandom_range(FRAME, 1);
            ul = (n < FRAME) ? 1'b1 : 1'($urandom_range(1, 0));
            for (int i = 0; i < FRAME; i++) begin
                case ($urandom_range(3, 0))
                    0: fr[i] = 16'h8000;
                    1: fr[i] = 16'h7FFF;
                    2: fr[i] = WIDTH'($urandom_range(4, 0)) - 16'd2;
                    default: fr[i] = WIDTH'($urandom);
                endcase
            end
            m  = fr[0];
            mi = 0;
            for (int i = 1; i < n; i++)
                if ($signed(fr[i]) > $signed(m)) begin
                    m  = fr[i];
                    mi = i;
                end
            run_frame($sformatf("rnd%0d", f), fr, n, ul, 2, m, mi, n,
                      $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
